// File: rtl/fpadd_pkg.sv
// Shared constants and types for the FP adder batch front end.
package fpadd_pkg;

  // Avalon word addresses
  localparam logic [3:0] ADDR_A    = 4'd0;
  localparam logic [3:0] ADDR_B    = 4'd1;
  localparam logic [3:0] ADDR_RES  = 4'd2;
  localparam logic [3:0] ADDR_STAT = 4'd3;

  // Status word bit positions (also used for the clear bits on a status write)
  localparam int STAT_OP_FULL     = 0;
  localparam int STAT_RES_EMPTY   = 1;
  localparam int STAT_OVF         = 2;
  localparam int STAT_UDF         = 3;
  localparam int STAT_RES_CNT_LSB = 8;
  localparam int STAT_OP_CNT_LSB  = 16;

  // One queued addition: operand A in the upper word, operand B in the lower
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } op_pair_t;

endpackage

// File: rtl/fpadd_fifo.sv
// Synchronous FIFO with occupancy count; full/empty are derived from the count.
// Push while full and pop while empty are ignored, so callers may strobe freely.
module fpadd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_MAX);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage array; contents need no reset because the count gates every read
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fpadd_batch_ctrl.sv
// Avalon-MM slave that queues operand pairs, streams them into an external
// fixed-latency FP adder and collects the sums for the CPU to read back.
module fpadd_batch_ctrl
  import fpadd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LAT   = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_z
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic           w_acc_wr;
  logic           w_acc_rd;
  op_pair_t       w_op_din;
  op_pair_t       w_op_head;
  logic           w_op_push;
  logic           w_op_full;
  logic           w_op_empty;
  logic [CW-1:0]  w_op_count;
  logic           w_issue;
  logic [31:0]    w_res_head;
  logic           w_res_push;
  logic           w_res_pop;
  logic           w_res_full;
  logic           w_res_empty;
  logic [CW-1:0]  w_res_count;
  logic           w_capture;
  logic [7:0]     w_inflight;
  logic [LAT-1:0] w_vpipe_next;
  logic [31:0]    w_status;

  // r_issued marks the cycle the pair sits on add_a/add_b; r_vpipe then
  // follows it for LAT cycles so that r_vpipe[LAT-1] lines up with add_z.
  logic           r_issued;
  logic [LAT-1:0] r_vpipe;
  logic [31:0]    r_a_stage;
  logic           r_ovf;
  logic           r_udf;

  assign w_acc_wr   = chipselect && write;
  assign w_acc_rd   = chipselect && read;
  assign w_op_din.a = r_a_stage;
  assign w_op_din.b = writedata;
  assign w_op_push  = w_acc_wr && (address == ADDR_B) && !w_op_full;
  assign w_capture  = r_vpipe[LAT-1];
  assign w_res_push = w_capture && !w_res_full;
  assign w_res_pop  = w_acc_rd && (address == ADDR_RES) && !w_res_empty;

  // Credit: every issued pair not yet captured holds a future result slot
  assign w_issue = !w_op_empty &&
                   ((9'(w_inflight) + 9'(w_res_count)) < 9'(DEPTH));

  fpadd_fifo #(.WIDTH($bits(op_pair_t)), .DEPTH(DEPTH)) u_op_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_op_push),
    .i_pop   (w_issue),
    .i_din   (w_op_din),
    .o_dout  (w_op_head),
    .o_full  (w_op_full),
    .o_empty (w_op_empty),
    .o_count (w_op_count)
  );

  fpadd_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_res_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_res_push),
    .i_pop   (w_res_pop),
    .i_din   (add_z),
    .o_dout  (w_res_head),
    .o_full  (w_res_full),
    .o_empty (w_res_empty),
    .o_count (w_res_count)
  );

  // Count results still travelling through the adder
  always_comb begin
    w_inflight = {7'd0, r_issued};
    for (int i = 0; i < LAT; i++) begin
      w_inflight = w_inflight + {7'd0, r_vpipe[i]};
    end
  end

  // Valid pipe shifts one stage per clock, fed by the issue marker
  always_comb begin
    w_vpipe_next    = r_vpipe << 1;
    w_vpipe_next[0] = r_issued;
  end

  // Status word assembled from the state at the start of the cycle
  always_comb begin
    w_status = '0;
    w_status[STAT_OP_FULL]              = w_op_full;
    w_status[STAT_RES_EMPTY]            = w_res_empty;
    w_status[STAT_OVF]                  = r_ovf;
    w_status[STAT_UDF]                  = r_udf;
    w_status[STAT_RES_CNT_LSB +: 8]     = 8'(w_res_count);
    w_status[STAT_OP_CNT_LSB +: 8]      = 8'(w_op_count);
  end

  // Adder-side registers: drive the popped pair and track its latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      add_a    <= '0;
      add_b    <= '0;
      r_issued <= 1'b0;
      r_vpipe  <= '0;
    end else begin
      r_issued <= w_issue;
      r_vpipe  <= w_vpipe_next;
      if (w_issue) begin
        add_a <= w_op_head.a;
        add_b <= w_op_head.b;
      end
    end
  end

  // Bus-side registers: staging, sticky error flags and read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_stage <= '0;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
      readdata  <= '0;
    end else begin
      if (w_acc_wr) begin
        if (address == ADDR_A) r_a_stage <= writedata;
        if ((address == ADDR_B) && w_op_full) r_ovf <= 1'b1;
        if (address == ADDR_STAT) begin
          if (writedata[STAT_OVF]) r_ovf <= 1'b0;
          if (writedata[STAT_UDF]) r_udf <= 1'b0;
        end
      end
      if (w_acc_rd) begin
        case (address)
          ADDR_RES: begin
            if (w_res_empty) begin
              readdata <= '0;
              r_udf    <= 1'b1;
            end else begin
              readdata <= w_res_head;
            end
          end
          ADDR_STAT: readdata <= w_status;
          default:   readdata <= '0;
        endcase
      end
    end
  end

endmodule
